tl_mmio_client: RTL and testbench
=================================

Name: tl_mmio_client

Overview:
- Single-outstanding uncached TileLink client (initiator) that converts simple register read/write commands into single-beat Get/Put Acquires and returns Grant data as a response.
- Drives the acquire/grant port of memory-mapped TileLink managers such as the PRCI timer/IPI block.
- Used by debug and bring-up logic and by peripheral sequencers that need MMIO access without a core.
- Adds a transaction-ID check and a grant timeout so a wedged manager cannot hang the requester.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles to wait in GNT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=Put, 0=Get
- cmd_addr  in  32  byte address
- cmd_wdata  in  64  write data, full 64-bit lane
- cmd_wmask  in  8  byte-lane write mask, unshifted
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  64  read data; 0 for writes and errors
- rsp_err  out  1  timeout or bad grant type
- io_tl_acquire_ready  in  1
- io_tl_acquire_valid  out  1
- io_tl_acquire_bits_addr_block  out  26  cmd_addr[31:6]
- io_tl_acquire_bits_client_xact_id  out  2  current ID
- io_tl_acquire_bits_addr_beat  out  3  cmd_addr[5:3]
- io_tl_acquire_bits_is_builtin_type  out  1  constant 1
- io_tl_acquire_bits_a_type  out  3  Get=0, Put=2
- io_tl_acquire_bits_union  out  12  see Behaviour
- io_tl_acquire_bits_data  out  64  wdata for Put, 0 for Get
- io_tl_grant_ready  out  1  constant 1
- io_tl_grant_valid  in  1
- io_tl_grant_bits_addr_beat  in  3  ignored
- io_tl_grant_bits_client_xact_id  in  2
- io_tl_grant_bits_manager_xact_id  in  1  ignored
- io_tl_grant_bits_is_builtin_type  in  1
- io_tl_grant_bits_g_type  in  4
- io_tl_grant_bits_data  in  64
- busy  out  1  state != IDLE
- err_unexpected_grant  out  1  sticky stray or mismatched grant

Behaviour:
- Reset: state IDLE; xact_id=0; timeout counter=0; err_unexpected_grant=0; acquire_valid=0; rsp_valid=0; rsp_rdata=0; rsp_err=0. Reset mid-operation abandons the transaction immediately; the attached managers reset together with this block.
- Union encoding for Get: {addr[2:0], 3'h3 (64-bit), 5'h00, 1'b1}.
- Union encoding for Put: {3'h0, wmask[7:0], 1'b1}.
- Expected grant: Get → g_type 4 (getDataBeat); Put → g_type 3 (putAck).
- All acquire fields come from registers captured at command accept and are stable while acquire_valid=1.
- IDLE: cmd_ready=1 only in this state. On command fire, latch the command and go to ACQ.
- ACQ: acquire_valid=1. Hold until acquire_ready, then go to GNT with counter=0.
- GNT, matching grant (grant_valid and client_xact_id==xact_id):
  - rsp_err = (is_builtin_type==0) | (g_type != expected).
  - rsp_rdata = grant data if Get and !rsp_err, else 0.
  - Go to RSP.
- GNT, mismatched ID: consume the grant, set err_unexpected_grant, stay in GNT; the counter keeps running.
- GNT, no matching grant: counter increments. When counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0) and no matching grant that cycle → RSP with rsp_err=1, rdata=0. If a matching grant arrives on the timeout cycle, the grant wins.
- RSP: rsp_valid=1 with data held stable until rsp_ready. On fire: go to IDLE, xact_id <= xact_id+1 (wraps 3→0), whether the transaction succeeded or errored.
- A grant arriving in IDLE/ACQ/RSP is consumed and sets err_unexpected_grant, e.g. a late grant after a timeout. err_unexpected_grant clears only on reset.
- Minimum latency: command fire at cycle T → acquire_valid at T+1; acquire_ready at T+1 → GNT at T+2; grant at T+2 → rsp_valid at T+3. Back-to-back: next cmd_ready the cycle after rsp fire.
- Exactly one transaction is outstanding at a time; no Acquire is issued while in GNT or RSP.

Test Plan:
- Read 0x0000_8000 with manager replying g_type 4, id 0, data 0x0000_0000_0000_1234 → acquire addr_block 0x200, beat 0, a_type 0, union 0x0C1; rsp_rdata 0x1234, rsp_err 0, first rsp_valid 3 cycles after command.
- Write 0x0000_4008, wdata 0xDEAD_BEEF_0000_0001, wmask 0xFF; manager ackes g_type 3 → a_type 2, beat 1, union 0x1FF; rsp_err 0, rdata 0; next command carries client_xact_id 1.
- Manager silent, TIMEOUT_CYCLES=16 → rsp_err 1 at 16 GNT cycles. A later grant with id 0 sets err_unexpected_grant, and the next transaction uses id 1.
- Grant with id 2 while expecting id 0, then a correct grant → mismatch flagged and consumed; correct response delivered.
- acquire_ready held low 5 cycles, rsp_ready low 4 cycles → acquire fields stable and rsp_valid/data held; cmd_ready stays 0 throughout.
- Read answered with g_type 3 → rsp_err 1, rdata 0. Four consecutive transactions then show IDs 0,1,2,3 and wrap to 0 on the fifth.

Source files
------------

// File: rtl/tl_mmio_client.sv
// tl_mmio_client
//   Single-outstanding uncached TileLink client. A simple register command
//   (read or write of one 64-bit lane) becomes a single-beat built-in Get or
//   Put Acquire. The matching Grant comes back as a response. A transaction-ID
//   check and an optional grant timeout make sure that a wedged or confused
//   manager cannot hang the requester.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   cmd_*                   command channel (valid/ready), accepted only in IDLE
//   rsp_*                   response channel (valid/ready), data held until accepted
//   io_tl_acquire_*         outgoing Acquire (valid/ready)
//   io_tl_grant_*           incoming Grant (always ready)
//   busy                    high whenever a transaction is in progress
//   err_unexpected_grant    sticky flag for stray or wrong-ID grants
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. A source keeps valid and its
// payload stable until that edge.
module tl_mmio_client #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [7:0]  cmd_wmask,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,

    input  logic        io_tl_acquire_ready,
    output logic        io_tl_acquire_valid,
    output logic [25:0] io_tl_acquire_bits_addr_block,
    output logic [1:0]  io_tl_acquire_bits_client_xact_id,
    output logic [2:0]  io_tl_acquire_bits_addr_beat,
    output logic        io_tl_acquire_bits_is_builtin_type,
    output logic [2:0]  io_tl_acquire_bits_a_type,
    output logic [11:0] io_tl_acquire_bits_union,
    output logic [63:0] io_tl_acquire_bits_data,

    output logic        io_tl_grant_ready,
    input  logic        io_tl_grant_valid,
    input  logic [2:0]  io_tl_grant_bits_addr_beat,
    input  logic [1:0]  io_tl_grant_bits_client_xact_id,
    input  logic        io_tl_grant_bits_manager_xact_id,
    input  logic        io_tl_grant_bits_is_builtin_type,
    input  logic [3:0]  io_tl_grant_bits_g_type,
    input  logic [63:0] io_tl_grant_bits_data,

    output logic        busy,
    output logic        err_unexpected_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_GNT  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [2:0] A_TYPE_GET      = 3'd0;
    localparam logic [2:0] A_TYPE_PUT      = 3'd2;
    localparam logic [3:0] G_TYPE_PUT_ACK  = 4'd3;
    localparam logic [3:0] G_TYPE_GET_DATA = 4'd4;

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t            state_q, state_d;
    logic [1:0]        xact_id_q, xact_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [63:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              err_unexp_q, err_unexp_d;

    logic              grant_id_match;
    logic              grant_bad;
    logic [3:0]        expected_g_type;
    logic              timeout_hit;

    // The grant beat and manager ID carry nothing this client needs.
    logic              unused_grant_bits;
    assign unused_grant_bits = ^{io_tl_grant_bits_addr_beat,
                                 io_tl_grant_bits_manager_xact_id};

    assign expected_g_type = write_q ? G_TYPE_PUT_ACK : G_TYPE_GET_DATA;
    assign grant_id_match  = io_tl_grant_valid &&
                             (io_tl_grant_bits_client_xact_id == xact_id_q);
    assign grant_bad       = !io_tl_grant_bits_is_builtin_type ||
                             (io_tl_grant_bits_g_type != expected_g_type);
    assign timeout_hit     = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        xact_id_d   = xact_id_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_unexp_d = err_unexp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wmask_d = cmd_wmask;
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (io_tl_acquire_ready) begin
                    cnt_d   = '0;
                    state_d = ST_GNT;
                end
            end
            ST_GNT: begin
                if (grant_id_match) begin
                    // A matching grant beats a timeout landing in the same cycle.
                    rsp_err_d   = grant_bad;
                    rsp_rdata_d = (!write_q && !grant_bad) ? io_tl_grant_bits_data : 64'd0;
                    state_d     = ST_RSP;
                end else begin
                    // A wrong-ID grant is swallowed; the wait continues.
                    if (io_tl_grant_valid) begin
                        err_unexp_d = 1'b1;
                    end
                    if (timeout_hit) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 64'd0;
                        state_d     = ST_RSP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    // The ID advances after errors too, so a late grant for
                    // the abandoned transaction cannot match the next one.
                    xact_id_d = xact_id_q + 2'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing is outstanding outside GNT, so any grant is stray.
        if (io_tl_grant_valid && (state_q != ST_GNT)) begin
            err_unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            xact_id_q   <= 2'd0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 64'd0;
            wmask_q     <= 8'd0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xact_id_q   <= xact_id_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    // All outputs are decodes of registered state or registered fields.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_unexpected_grant = err_unexp_q;

    assign io_tl_acquire_valid                = (state_q == ST_ACQ);
    assign io_tl_acquire_bits_addr_block      = addr_q[31:6];
    assign io_tl_acquire_bits_addr_beat       = addr_q[5:3];
    assign io_tl_acquire_bits_client_xact_id  = xact_id_q;
    assign io_tl_acquire_bits_is_builtin_type = 1'b1;
    assign io_tl_acquire_bits_a_type          = write_q ? A_TYPE_PUT : A_TYPE_GET;
    // Get: byte offset, 64-bit operand size, unused bits, alloc.
    // Put: write mask, alloc.
    assign io_tl_acquire_bits_union = write_q ? {3'h0, wmask_q, 1'b1}
                                              : {addr_q[2:0], 3'h3, 5'h00, 1'b1};
    assign io_tl_acquire_bits_data  = write_q ? wdata_q : 64'd0;

    assign io_tl_grant_ready = 1'b1;

endmodule

// File: tb/tb_tl_mmio_client.sv
// Bench for tl_mmio_client: a fixed table of transactions with hand-derived
// expectations, a few hand-written corner sequences (late grant, reset in the
// middle of a transaction, ID wrap), then randomized transactions whose
// expectations come from a small model of the command/grant rules.
module tb_tl_mmio_client;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wmask = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        acq_ready = 1'b0, acq_valid;
    logic [25:0] acq_block;
    logic [1:0]  acq_id;
    logic [2:0]  acq_beat, acq_atype;
    logic        acq_builtin;
    logic [11:0] acq_union;
    logic [63:0] acq_data;
    logic        gnt_ready;
    logic        gnt_valid = 1'b0;
    logic [2:0]  gnt_beat = '0;
    logic [1:0]  gnt_id = '0;
    logic        gnt_mid = 1'b0, gnt_builtin = 1'b1;
    logic [3:0]  gnt_gtype = '0;
    logic [63:0] gnt_data = '0;
    logic        busy, err_flag;

    tl_mmio_client #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_tl_acquire_ready(acq_ready), .io_tl_acquire_valid(acq_valid),
        .io_tl_acquire_bits_addr_block(acq_block), .io_tl_acquire_bits_client_xact_id(acq_id),
        .io_tl_acquire_bits_addr_beat(acq_beat), .io_tl_acquire_bits_is_builtin_type(acq_builtin),
        .io_tl_acquire_bits_a_type(acq_atype), .io_tl_acquire_bits_union(acq_union),
        .io_tl_acquire_bits_data(acq_data),
        .io_tl_grant_ready(gnt_ready), .io_tl_grant_valid(gnt_valid),
        .io_tl_grant_bits_addr_beat(gnt_beat), .io_tl_grant_bits_client_xact_id(gnt_id),
        .io_tl_grant_bits_manager_xact_id(gnt_mid), .io_tl_grant_bits_is_builtin_type(gnt_builtin),
        .io_tl_grant_bits_g_type(gnt_gtype), .io_tl_grant_bits_data(gnt_data),
        .busy(busy), .err_unexpected_grant(err_flag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int model_id = 0;
    bit model_err = 1'b0;
    logic [64:0] exp_q[$];

    // gmode: 0 correct grant, 1 wrong g_type, 2 non-builtin, 3 silent, 4 wrong ID then correct
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          acq_dly;
        int          gnt_dly;
        int          gmode;
        int          rsp_dly;
        logic [63:0] gdata;
        logic [1:0]  exp_id;
        logic [25:0] exp_block;
        logic [2:0]  exp_beat;
        logic [2:0]  exp_atype;
        logic [11:0] exp_union;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0; acq_ready = 1'b0; gnt_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_id = 0;
        model_err = 1'b0;
        exp_q.delete();
    endtask

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [63:0] wdata, logic [7:0] wmask,
                                int ad, int gd, int gm, int rd, logic [63:0] gdata,
                                logic [1:0] id, logic [25:0] blk, logic [2:0] beat,
                                logic [2:0] at, logic [11:0] un, logic [63:0] rdata, bit err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.acq_dly = ad; v.gnt_dly = gd; v.gmode = gm; v.rsp_dly = rd; v.gdata = gdata;
        v.exp_id = id; v.exp_block = blk; v.exp_beat = beat; v.exp_atype = at;
        v.exp_union = un; v.exp_rdata = rdata; v.exp_err = err;
        return v;
    endfunction

    // Reference model: expected acquire fields and response from the
    // command/grant rules, using plain arithmetic on the byte address.
    function automatic vec_t model_vec(bit wr, logic [31:0] addr, logic [63:0] wdata, logic [7:0] wmask,
                                       int ad, int gd, int gm, int rd, logic [63:0] gdata);
        vec_t v;
        bit err;
        int unsigned a;
        a = addr;
        err = (gm == 1) || (gm == 2) || (gm == 3);
        v = mk(wr, addr, wdata, wmask, ad, gd, gm, rd, gdata,
               2'(model_id % 4), 26'(a / 64), 3'((a / 8) % 8), wr ? 3'd2 : 3'd0,
               wr ? 12'(int'(wmask) * 2 + 1) : 12'((a % 8) * 512 + 3 * 64 + 1),
               (!wr && !err) ? gdata : 64'd0, err);
        return v;
    endfunction

    task automatic check_acq(input vec_t v);
        check("acq_valid", acq_valid, 1);
        check("acq_block", acq_block, v.exp_block);
        check("acq_beat", acq_beat, v.exp_beat);
        check("acq_atype", acq_atype, v.exp_atype);
        check("acq_union", acq_union, v.exp_union);
        check("acq_id", acq_id, v.exp_id);
        check("acq_builtin", acq_builtin, 1);
        check("acq_data", acq_data, v.wr ? v.wdata : 64'd0);
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input vec_t v);
        int unsigned c0;
        int n, exp_lat;
        logic [64:0] e;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wmask = v.wmask;
        c0 = cyc;
        @(negedge clk);
        // Scramble the command bus: acquire fields must come from the latch.
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = {$urandom, $urandom}; cmd_wmask = 8'($urandom);
        for (int i = 0; i < v.acq_dly; i++) begin
            check_acq(v);
            @(negedge clk);
        end
        check_acq(v);
        acq_ready = 1'b1;
        @(negedge clk);
        acq_ready = 1'b0;
        check("acq_drop", acq_valid, 0);
        check("busy_gnt", busy, 1);
        if (v.gmode == 3) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            exp_lat = 2 + v.acq_dly + TO;
        end else begin
            repeat (v.gnt_dly) @(negedge clk);
            if (v.gmode == 4) begin
                gnt_valid = 1'b1; gnt_id = v.exp_id ^ 2'd2; gnt_builtin = 1'b1;
                gnt_gtype = v.wr ? 4'd3 : 4'd4; gnt_data = {$urandom, $urandom};
                gnt_beat = 3'($urandom); gnt_mid = 1'($urandom);
                @(negedge clk);
                gnt_valid = 1'b0;
                model_err = 1'b1;
                check("mismatch_flag", err_flag, 1);
                check("mismatch_stay", rsp_valid, 0);
            end
            gnt_valid = 1'b1; gnt_id = v.exp_id;
            gnt_builtin = (v.gmode == 2) ? 1'b0 : 1'b1;
            if (v.gmode == 1) gnt_gtype = v.wr ? 4'd4 : 4'd3;
            else              gnt_gtype = v.wr ? 4'd3 : 4'd4;
            gnt_data = v.gdata; gnt_beat = 3'($urandom); gnt_mid = 1'($urandom);
            @(negedge clk);
            gnt_valid = 1'b0;
            exp_lat = 3 + v.acq_dly + v.gnt_dly + ((v.gmode == 4) ? 1 : 0);
        end
        check("latency", cyc - c0, exp_lat);
        exp_q.push_back({v.exp_err, v.exp_rdata});
        for (int i = 0; i < v.rsp_dly; i++) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_rdata", rsp_rdata, v.exp_rdata);
            check("rsp_hold_err", rsp_err, v.exp_err);
            check("cmd_ready_rsp", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rsp_valid", rsp_valid, 1);
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[63:0]);
        check("rsp_err", rsp_err, e[64]);
        @(negedge clk);
        rsp_ready = 1'b0;
        model_id = (model_id + 1) % 4;
        check("rsp_drop", rsp_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("err_flag", err_flag, model_err);
    endtask

    // ---------------- test ----------------
    vec_t vecs[8];
    int gm_pick[7] = '{0, 0, 0, 1, 2, 3, 4};

    initial begin
        vecs[0] = mk(0, 32'h0000_8000, 64'h0, 8'h00, 0, 0, 0, 0, 64'h1234,
                     2'd0, 26'h200, 3'd0, 3'd0, 12'h0C1, 64'h1234, 0);
        vecs[1] = mk(1, 32'h0000_4008, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 1, 0, 0, 64'hFFFF,
                     2'd1, 26'h100, 3'd1, 3'd2, 12'h1FF, 64'h0, 0);
        vecs[2] = mk(0, 32'h1000_0015, 64'h0, 8'h00, 1, 0, 1, 1, 64'hAAAA,
                     2'd2, 26'h40_0000, 3'd2, 3'd0, 12'hAC1, 64'h0, 1);
        vecs[3] = mk(1, 32'h2000_0030, 64'h0123_4567_89AB_CDEF, 8'h5A, 0, 0, 2, 0, 64'h5555,
                     2'd3, 26'h80_0000, 3'd6, 3'd2, 12'h0B5, 64'h0, 1);
        vecs[4] = mk(0, 32'hFFFF_FFF8, 64'h0, 8'h00, 5, 2, 0, 4, 64'hCAFE_F00D_1234_5678,
                     2'd0, 26'h3FF_FFFF, 3'd7, 3'd0, 12'h0C1, 64'hCAFE_F00D_1234_5678, 0);
        vecs[5] = mk(0, 32'h0000_0040, 64'h0, 8'h00, 0, TO - 1, 0, 0, 64'h55,
                     2'd1, 26'h1, 3'd0, 3'd0, 12'h0C1, 64'h55, 0);
        vecs[6] = mk(1, 32'h0000_0008, 64'h77, 8'h01, 0, 0, 3, 2, 64'h0,
                     2'd2, 26'h0, 3'd1, 3'd2, 12'h003, 64'h0, 1);
        vecs[7] = mk(0, 32'h0000_0100, 64'h0, 8'h00, 0, 0, 0, 0, 64'h99,
                     2'd3, 26'h4, 3'd0, 3'd0, 12'h0C1, 64'h99, 0);

        do_reset();
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_acq_valid", acq_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_id", acq_id, 0);
        check("gnt_ready", gnt_ready, 1);

        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                // Late grant for the transaction that timed out (ID 2).
                @(negedge clk);
                check("late_pre", err_flag, 0);
                gnt_valid = 1'b1; gnt_id = 2'd2; gnt_builtin = 1'b1; gnt_gtype = 4'd3;
                @(negedge clk);
                gnt_valid = 1'b0;
                model_err = 1'b1;
                check("late_flag", err_flag, 1);
                check("late_idle", busy, 0);
            end
            run_txn(vecs[i]);
        end

        // Reset while an Acquire is pending drops it at once.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_acq", acq_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_acq_drop", acq_valid, 0);
        check("midrst_flag", err_flag, 0);
        do_reset();

        // Wrong-ID grant followed by the right one.
        run_txn(model_vec(0, 32'h0000_2010, 64'h0, 8'h0, 0, 1, 4, 0, 64'h0BAD_F00D));

        // ID sequence 0,1,2,3 then wrap to 0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = model_vec(i[0], 32'h100 * i, 64'h10 + i, 8'h0F, 0, 0, 0, 0, 64'hA0 + i);
            v.exp_id = 2'(i % 4);
            run_txn(v);
        end

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int gm, gd;
            gm = gm_pick[$urandom_range(0, 6)];
            gd = (gm == 4) ? $urandom_range(0, 4) : $urandom_range(0, TO - 1);
            v = model_vec(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                          $urandom_range(0, 3), gd, gm, $urandom_range(0, 3),
                          {$urandom, $urandom});
            run_txn(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so a stuck DUT cannot hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
